// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register, write-back select, 32-entry register file with
// same-cycle write bypass on both ID read ports, and a committed-write counter.

// One ID-stage read port: $zero, then in-flight write-back bypass, then array.
module mem_wb_rd_port #(
  parameter int DATA_W = 32,
  parameter int REGS   = 32,
  parameter int AW     = $clog2(REGS)
) (
  input  logic [AW-1:0]                 addr,
  input  logic [REGS-1:0][DATA_W-1:0]   regs,
  input  logic                          byp_en,
  input  logic [AW-1:0]                 byp_reg,
  input  logic [DATA_W-1:0]             byp_data,
  output logic [DATA_W-1:0]             data
);

  // Priority read mux; bypass lets ID see the value being committed this edge.
  always_comb begin
    data = regs[addr];
    if (addr == '0)
      data = '0;
    else if (byp_en && (addr == byp_reg))
      data = byp_data;
  end

endmodule

module mem_wb_writeback #(
  parameter int DATA_W = 32,
  parameter int REGS   = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stall,
  input  logic                          flush,
  input  logic [1:0]                    mem_control_wb,
  input  logic [DATA_W-1:0]             read_data,
  input  logic [DATA_W-1:0]             mem_ALU_result,
  input  logic [$clog2(REGS)-1:0]       mem_Write_reg,
  input  logic [$clog2(REGS)-1:0]       rs_addr,
  input  logic [$clog2(REGS)-1:0]       rt_addr,
  output logic [DATA_W-1:0]             rs_data,
  output logic [DATA_W-1:0]             rt_data,
  output logic [DATA_W-1:0]             wb_write_data,
  output logic [$clog2(REGS)-1:0]       wb_write_reg,
  output logic                          wb_reg_write,
  output logic [31:0]                   wb_count
);

  localparam int AW      = $clog2(REGS);
  localparam int NUM_RDP = 2;

  // ctl[1] = RegWrite, ctl[0] = MemtoReg
  typedef struct packed {
    logic [1:0]        ctl;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [AW-1:0]     wreg;
  } mwb_t;

  mwb_t                          pipe_d, pipe_q;
  logic [REGS-1:0][DATA_W-1:0]   regs_d, regs_q;
  logic [31:0]                   count_d, count_q;

  logic [NUM_RDP-1:0][AW-1:0]     rdp_addr;
  logic [NUM_RDP-1:0][DATA_W-1:0] rdp_data;

  // MEM/WB next state: flush beats stall, stall holds, otherwise capture MEM.
  always_comb begin
    pipe_d = pipe_q;
    if (flush)
      pipe_d = '0;
    else if (!stall) begin
      pipe_d.ctl  = mem_control_wb;
      pipe_d.rd   = read_data;
      pipe_d.alu  = mem_ALU_result;
      pipe_d.wreg = mem_Write_reg;
    end
  end

  // Write-back select and effective enable; $zero is never a real target.
  always_comb begin
    wb_write_data = pipe_q.ctl[0] ? pipe_q.rd : pipe_q.alu;
    wb_write_reg  = pipe_q.wreg;
    wb_reg_write  = pipe_q.ctl[1] && (pipe_q.wreg != '0);
  end

  // Commit from pre-edge MEM/WB contents, independent of stall/flush, so a
  // held entry simply rewrites the same value each stalled cycle.
  always_comb begin
    regs_d = regs_q;
    if (wb_reg_write)
      regs_d[wb_write_reg] = wb_write_data;
    regs_d[0] = '0;
  end

  // Counter counts every committing cycle, stalled re-commits included.
  always_comb begin
    count_d = count_q;
    if (wb_reg_write)
      count_d = count_q + 32'd1;
  end

  // State flops; async reset drops any in-flight write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q  <= '0;
      regs_q  <= '0;
      count_q <= '0;
    end else begin
      pipe_q  <= pipe_d;
      regs_q  <= regs_d;
      count_q <= count_d;
    end
  end

  assign wb_count    = count_q;
  assign rdp_addr[0] = rs_addr;
  assign rdp_addr[1] = rt_addr;
  assign rs_data     = rdp_data[0];
  assign rt_data     = rdp_data[1];

  for (genvar g = 0; g < NUM_RDP; g++) begin : g_rdp
    mem_wb_rd_port #(.DATA_W(DATA_W), .REGS(REGS), .AW(AW)) u_rdp (
      .addr     (rdp_addr[g]),
      .regs     (regs_q),
      .byp_en   (wb_reg_write),
      .byp_reg  (wb_write_reg),
      .byp_data (wb_write_data),
      .data     (rdp_data[g])
    );
  end

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed bench for mem_wb_writeback: reset, ALU/load write-back, $zero,
// stall/flush, back-to-back same-register writes, async reset mid-stream.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush;
  logic [1:0]  mem_control_wb;
  logic [31:0] read_data, mem_ALU_result;
  logic [4:0]  mem_Write_reg, rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data, wb_write_data, wb_count;
  logic [4:0]  wb_write_reg;
  logic        wb_reg_write;

  int vecs = 0;
  int errs = 0;

  mem_wb_writeback dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .flush          (flush),
    .mem_control_wb (mem_control_wb),
    .read_data      (read_data),
    .mem_ALU_result (mem_ALU_result),
    .mem_Write_reg  (mem_Write_reg),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .wb_write_data  (wb_write_data),
    .wb_write_reg   (wb_write_reg),
    .wb_reg_write   (wb_reg_write),
    .wb_count       (wb_count)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ctl, input logic [31:0] rd,
                       input logic [31:0] alu, input logic [4:0] wr);
    mem_control_wb = ctl;
    read_data      = rd;
    mem_ALU_result = alu;
    mem_Write_reg  = wr;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(2'b11, 32'hFFFF_0000, 32'h1234_5678, 5'd5);
    rs_addr = 5'd5; rt_addr = 5'd5;
    tick(); tick();
    vecs++; if (wb_write_data !== 32'h0) begin errs++; $display("FAIL rst_wdata got %h want 0", wb_write_data); end
    vecs++; if (wb_write_reg !== 5'd0) begin errs++; $display("FAIL rst_wreg got %0d want 0", wb_write_reg); end
    vecs++; if (wb_reg_write !== 1'b0) begin errs++; $display("FAIL rst_we got %b want 0", wb_reg_write); end
    vecs++; if (rs_data !== 32'h0) begin errs++; $display("FAIL rst_rs5 got %h want 0", rs_data); end
    vecs++; if (wb_count !== 32'd0) begin errs++; $display("FAIL rst_count got %0d want 0", wb_count); end
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    reset = 1'b1;
  endtask

  task automatic test_alu_wb();
    drive(2'b10, 32'h0, 32'h0000_0020, 5'd21);
    rs_addr = 5'd21;
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    vecs++; if (wb_write_data !== 32'h20) begin errs++; $display("FAIL alu_wdata got %h want 20", wb_write_data); end
    vecs++; if (wb_reg_write !== 1'b1) begin errs++; $display("FAIL alu_we got %b want 1", wb_reg_write); end
    vecs++; if (rs_data !== 32'h20) begin errs++; $display("FAIL alu_bypass got %h want 20", rs_data); end
    vecs++; if (wb_count !== 32'd0) begin errs++; $display("FAIL alu_count_pre got %0d want 0", wb_count); end
    tick();
    vecs++; if (wb_count !== 32'd1) begin errs++; $display("FAIL alu_count got %0d want 1", wb_count); end
    vecs++; if (rs_data !== 32'h20) begin errs++; $display("FAIL alu_array got %h want 20", rs_data); end
  endtask

  task automatic test_load_wb();
    drive(2'b11, 32'hDEAD_BEEF, 32'h10, 5'd8);
    rt_addr = 5'd8;
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    vecs++; if (wb_write_data !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ld_wdata got %h want deadbeef", wb_write_data); end
    vecs++; if (wb_write_reg !== 5'd8) begin errs++; $display("FAIL ld_wreg got %0d want 8", wb_write_reg); end
    tick();
    vecs++; if (rt_data !== 32'hDEAD_BEEF) begin errs++; $display("FAIL ld_array got %h want deadbeef", rt_data); end
    vecs++; if (wb_count !== 32'd2) begin errs++; $display("FAIL ld_count got %0d want 2", wb_count); end
  endtask

  task automatic test_zero();
    drive(2'b10, 32'h0, 32'h1234, 5'd0);
    rs_addr = 5'd0;
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    vecs++; if (wb_reg_write !== 1'b0) begin errs++; $display("FAIL z_we got %b want 0", wb_reg_write); end
    vecs++; if (wb_write_data !== 32'h1234) begin errs++; $display("FAIL z_wdata got %h want 1234", wb_write_data); end
    vecs++; if (rs_data !== 32'h0) begin errs++; $display("FAIL z_rs0 got %h want 0", rs_data); end
    tick();
    vecs++; if (wb_count !== 32'd2) begin errs++; $display("FAIL z_count got %0d want 2", wb_count); end
    vecs++; if (rs_data !== 32'h0) begin errs++; $display("FAIL z_rs0_post got %h want 0", rs_data); end
  endtask

  task automatic test_stall_flush();
    drive(2'b10, 32'h0, 32'hA5, 5'd3);
    rs_addr = 5'd3;
    tick();
    stall = 1'b1;
    drive(2'b10, 32'h0, 32'h77, 5'd4);
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if (wb_write_reg !== 5'd3) begin errs++; $display("FAIL st_wreg[%0d] got %0d want 3", i, wb_write_reg); end
      vecs++; if (wb_count !== 32'd3 + 32'(i)) begin errs++; $display("FAIL st_count[%0d] got %0d want %0d", i, wb_count, 3 + i); end
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; stall = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    vecs++; if (wb_reg_write !== 1'b0) begin errs++; $display("FAIL fl_we got %b want 0", wb_reg_write); end
    vecs++; if (wb_write_data !== 32'h0) begin errs++; $display("FAIL fl_wdata got %h want 0", wb_write_data); end
    vecs++; if (wb_count !== 32'd6) begin errs++; $display("FAIL fl_count got %0d want 6", wb_count); end
    vecs++; if (rs_data !== 32'hA5) begin errs++; $display("FAIL fl_rs3 got %h want a5", rs_data); end
  endtask

  task automatic test_back_to_back();
    rs_addr = 5'd10; rt_addr = 5'd10;
    drive(2'b10, 32'h0, 32'h1, 5'd10);
    tick();
    drive(2'b11, 32'h2, 32'h9, 5'd10);
    vecs++; if (rs_data !== 32'h1) begin errs++; $display("FAIL b2b_byp1 got %h want 1", rs_data); end
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    vecs++; if (rt_data !== 32'h2) begin errs++; $display("FAIL b2b_byp2 got %h want 2", rt_data); end
    tick();
    vecs++; if (rs_data !== 32'h2) begin errs++; $display("FAIL b2b_array got %h want 2", rs_data); end
    vecs++; if (wb_count !== 32'd8) begin errs++; $display("FAIL b2b_count got %0d want 8", wb_count); end
  endtask

  task automatic test_async_reset();
    rs_addr = 5'd9; rt_addr = 5'd12;
    drive(2'b10, 32'h0, 32'h55, 5'd9);
    tick();
    drive(2'b10, 32'h0, 32'h66, 5'd12);
    tick();
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    vecs++; if (rs_data !== 32'h55) begin errs++; $display("FAIL ar_rs9_pre got %h want 55", rs_data); end
    vecs++; if (rt_data !== 32'h66) begin errs++; $display("FAIL ar_rt12_byp got %h want 66", rt_data); end
    #2 reset = 1'b0;
    #1;
    vecs++; if (wb_write_data !== 32'h0) begin errs++; $display("FAIL ar_wdata got %h want 0", wb_write_data); end
    vecs++; if (wb_reg_write !== 1'b0) begin errs++; $display("FAIL ar_we got %b want 0", wb_reg_write); end
    vecs++; if (rs_data !== 32'h0) begin errs++; $display("FAIL ar_rs9 got %h want 0", rs_data); end
    vecs++; if (wb_count !== 32'd0) begin errs++; $display("FAIL ar_count got %0d want 0", wb_count); end
    tick();
    reset = 1'b1;
    tick();
    vecs++; if (wb_count !== 32'd0) begin errs++; $display("FAIL ar_count_post got %0d want 0", wb_count); end
    vecs++; if (rt_data !== 32'h0) begin errs++; $display("FAIL ar_rt12_post got %h want 0", rt_data); end
    vecs++; if (rs_data !== 32'h0) begin errs++; $display("FAIL ar_rs9_post got %h want 0", rs_data); end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    rs_addr = 5'd0; rt_addr = 5'd0;
    drive(2'b00, 32'h0, 32'h0, 5'd0);
    #1;
    test_reset();
    test_alu_wb();
    test_load_wb();
    test_zero();
    test_stall_flush();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
